pend_req_arbiter: RTL and testbench

//  Upstream request-collection stage for the 8-to-3 highest-index priority encoder.

---
 rtl/pend_req_arbiter_pkg.sv | 27 ++
 rtl/pend_req_arbiter_enc.sv | 31 +++
 rtl/pend_req_arbiter.sv | 119 +++++++++++
 tb/tb_pend_req_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pend_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pend_req_arbiter_pkg
//   Shared constants and types for the pending-request arbiter slice.
//   N_REQ : number of request sources (fixed by the 8-to-3 encoder width)
//   IDX_W : width of a source index
//   CNT_W : width of the pending-count output (holds 0..N_REQ)
//   idx_t : source index type
//   popcount() : number of set bits in a request vector
// -----------------------------------------------------------------------------
package pend_req_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pend_req_arbiter_enc.sv
// -----------------------------------------------------------------------------
// pend_req_arbiter_enc
//   Highest-index priority encoder, 8 bits in, 3 bits out.
//   req_i : request vector
//   idx_o : index of the highest set bit; meaningless when req_i is zero,
//           so callers must qualify it with |req_i.
// -----------------------------------------------------------------------------
module pend_req_arbiter_enc
    import pend_req_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    output idx_t             idx_o
);

    // Priority encode: the highest set bit wins.
    always_comb begin
        idx_o = 3'd0;
        casez (req_i)
            8'b1???????: idx_o = 3'd7;
            8'b01??????: idx_o = 3'd6;
            8'b001?????: idx_o = 3'd5;
            8'b0001????: idx_o = 3'd4;
            8'b00001???: idx_o = 3'd3;
            8'b000001??: idx_o = 3'd2;
            8'b0000001?: idx_o = 3'd1;
            8'b00000001: idx_o = 3'd0;
            default:     idx_o = 3'd0;
        endcase
    end

endmodule

// File: rtl/pend_req_arbiter.sv
// -----------------------------------------------------------------------------
// pend_req_arbiter
//   Collects one-cycle request pulses from 8 sources into a pending vector,
//   issues the highest pending index on a valid/ready output stage and retires
//   that bit from the pending vector.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req_set   : one-cycle request pulses, bit i = source i
//   flush     : synchronous clear of all pending/output/error state
//   out_valid : out_idx carries a valid index
//   out_idx   : selected source index
//   out_ready : consumer accepts out_idx this cycle
//   pend_vec  : pending vector (excludes the index held in the output stage)
//   pend_cnt  : popcount of pend_vec
//   merge_err : sticky flag, request arrived for an already-pending bit
// -----------------------------------------------------------------------------
module pend_req_arbiter
    import pend_req_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_set,
    input  logic             flush,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pend_vec,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             merge_err
);

    logic [N_REQ-1:0] pend_vec_q, pend_vec_d;
    logic             out_valid_q, out_valid_d;
    idx_t             out_idx_q, out_idx_d;
    logic             merge_err_q, merge_err_d;

    logic             ld_s;
    logic             any_pend_s;
    logic             issue_s;
    idx_t             enc_idx_s;
    logic [N_REQ-1:0] clr_mask_s;
    logic             dup_s;

    pend_req_arbiter_enc u_enc (
        .req_i (pend_vec_q),
        .idx_o (enc_idx_s)
    );

    // Issue decision and clear mask; the encoder output is used only when
    // something is pending, so its zero-input value never reaches a register.
    always_comb begin
        ld_s       = ~out_valid_q | out_ready;
        any_pend_s = |pend_vec_q;
        issue_s    = ld_s & any_pend_s;
        if (issue_s) begin
            clr_mask_s = 8'b0000_0001 << enc_idx_s;
        end else begin
            clr_mask_s = {N_REQ{1'b0}};
        end
        // A request for the bit being retired this cycle re-pends; not a duplicate.
        dup_s = |(req_set & pend_vec_q & ~clr_mask_s);
    end

    // Next-state for pending vector, output stage and sticky error.
    always_comb begin
        pend_vec_d  = pend_vec_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        merge_err_d = merge_err_q;
        if (flush) begin
            pend_vec_d  = {N_REQ{1'b0}};
            out_valid_d = 1'b0;
            out_idx_d   = out_idx_q;
            merge_err_d = 1'b0;
        end else begin
            // Set wins over clear on the same bit.
            pend_vec_d = (pend_vec_q & ~clr_mask_s) | req_set;
            if (dup_s) begin
                merge_err_d = 1'b1;
            end else begin
                merge_err_d = merge_err_q;
            end
            if (ld_s) begin
                if (any_pend_s) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = enc_idx_s;
                end else begin
                    out_valid_d = 1'b0;
                    out_idx_d   = out_idx_q;
                end
            end else begin
                out_valid_d = out_valid_q;
                out_idx_d   = out_idx_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vec_q  <= {N_REQ{1'b0}};
            out_valid_q <= 1'b0;
            out_idx_q   <= 3'd0;
            merge_err_q <= 1'b0;
        end else begin
            pend_vec_q  <= pend_vec_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            merge_err_q <= merge_err_d;
        end
    end

    assign pend_vec  = pend_vec_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign merge_err = merge_err_q;
    assign pend_cnt  = popcount(pend_vec_q);

endmodule

// File: tb/tb_pend_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pend_req_arbiter
//   Directed testbench for pend_req_arbiter with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pend_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_set;
    logic       flush;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] pend_vec;
    logic [3:0] pend_cnt;
    logic       merge_err;

    int errors;
    int checks;

    pend_req_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_set   (req_set),
        .flush     (flush),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pend_vec  (pend_vec),
        .pend_cnt  (pend_cnt),
        .merge_err (merge_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare full observable state against expectations.
    task automatic expect_state(input string name, input logic ev, input logic [2:0] ei,
                                input logic [7:0] ep, input logic [3:0] ec, input logic em);
        checks++;
        if (out_valid !== ev || (ev && out_idx !== ei) || pend_vec !== ep ||
            pend_cnt !== ec || merge_err !== em) begin
            errors++;
            $display("FAIL %s: got valid=%b idx=%0d pend=%h cnt=%0d merr=%b, want valid=%b idx=%0d pend=%h cnt=%0d merr=%b",
                     name, out_valid, out_idx, pend_vec, pend_cnt, merge_err, ev, ei, ep, ec, em);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_set = 8'h00; flush = 1'b0; out_ready = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || pend_vec !== 8'h00 ||
            pend_cnt !== 4'd0 || merge_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got valid=%b idx=%0d pend=%h cnt=%0d merr=%b, want all zero",
                     out_valid, out_idx, pend_vec, pend_cnt, merge_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_req();
        out_ready = 1'b1;
        req_set = 8'h81; tick(); req_set = 8'h00;
        expect_state("two_pend",  1'b0, 3'd0, 8'h81, 4'd2, 1'b0);
        tick(); expect_state("two_idx7",  1'b1, 3'd7, 8'h01, 4'd1, 1'b0);
        tick(); expect_state("two_idx0",  1'b1, 3'd0, 8'h00, 4'd0, 1'b0);
        tick(); expect_state("two_empty", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_set = 8'h0C; tick(); req_set = 8'h00;
        expect_state("bp_pend", 1'b0, 3'd0, 8'h0C, 4'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); expect_state("bp_hold", 1'b1, 3'd3, 8'h04, 4'd1, 1'b0);
        end
        out_ready = 1'b1;
        tick(); expect_state("bp_idx2",  1'b1, 3'd2, 8'h00, 4'd0, 1'b0);
        tick(); expect_state("bp_empty", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic test_set_wins();
        out_ready = 1'b1;
        req_set = 8'h10; tick();
        expect_state("sw_pend", 1'b0, 3'd0, 8'h10, 4'd1, 1'b0);
        // req_set for bit 4 again in the very cycle it is loaded
        tick(); req_set = 8'h00;
        expect_state("sw_first",  1'b1, 3'd4, 8'h10, 4'd1, 1'b0);
        tick(); expect_state("sw_again", 1'b1, 3'd4, 8'h00, 4'd0, 1'b0);
        tick(); expect_state("sw_empty", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic test_duplicate();
        out_ready = 1'b0;
        req_set = 8'h01; tick(); req_set = 8'h00;
        tick(); expect_state("dup_fill", 1'b1, 3'd0, 8'h00, 4'd0, 1'b0);
        req_set = 8'h02; tick();
        expect_state("dup_first", 1'b1, 3'd0, 8'h02, 4'd1, 1'b0);
        tick(); req_set = 8'h00;
        expect_state("dup_err", 1'b1, 3'd0, 8'h02, 4'd1, 1'b1);
        tick(); expect_state("dup_sticky", 1'b1, 3'd0, 8'h02, 4'd1, 1'b1);
    endtask

    task automatic test_flush();
        // state: valid idx0 held, pend=02, merge_err=1
        flush = 1'b1; req_set = 8'hFF; tick();
        flush = 1'b0; req_set = 8'h00;
        expect_state("flush", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
        out_ready = 1'b1;
        tick(); expect_state("flush_after", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        req_set = 8'h01; tick(); req_set = 8'h00;
        tick();
        req_set = 8'hF0; tick(); req_set = 8'h00;
        expect_state("ar_pend", 1'b1, 3'd0, 8'hF0, 4'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || pend_vec !== 8'h00 ||
            pend_cnt !== 4'd0 || merge_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b idx=%0d pend=%h cnt=%0d merr=%b, want all zero",
                     out_valid, out_idx, pend_vec, pend_cnt, merge_err);
        end
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_state("ar_idle", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
        end
        req_set = 8'h20; tick(); req_set = 8'h00;
        tick(); expect_state("ar_new", 1'b1, 3'd5, 8'h00, 4'd0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_two_req();
        test_backpressure();
        test_set_wins();
        test_duplicate();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
